// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the NPC core sequencer.
//   ctrl_state_e : sequencer states, also exported on the debug state port
//   EBREAK_INST  : full encoding of ebreak, which halts the core
//   NOP_INST     : addi x0,x0,0, loaded into the IR at reset
package core_pkg;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4,
        ERR   = 3'd5
    } ctrl_state_e;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
    localparam logic [31:0] NOP_INST    = 32'h0000_0013;

endpackage

// File: rtl/defines.svh
// Opcode constants shared by the NPC core decode logic.
// Each value is the 7-bit major opcode found in instruction bits [6:0].
`ifndef CORE_DEFINES_SVH
`define CORE_DEFINES_SVH

`define LOAD_OPCODE    7'b0000011
`define STORE_OPCODE   7'b0100011
`define OP_IMM_OPCODE  7'b0010011
`define OP_OPCODE      7'b0110011
`define LUI_OPCODE     7'b0110111
`define AUIPC_OPCODE   7'b0010111
`define JAL_OPCODE     7'b1101111
`define JALR_OPCODE    7'b1100111
`define BRANCH_OPCODE  7'b1100011
`define SYSTEM_OPCODE  7'b1110011

`endif

// File: rtl/wait_timer.sv
// wait_timer: counts consecutive cycles spent waiting on a memory response.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   clear      : forces the count back to zero on the next edge
//   enable     : a waiting cycle; the count advances by one
//   expired    : this waiting cycle is the last one allowed (count == TIMEOUT-1)
// expired is qualified with enable so a response arriving in the final cycle
// (which drops enable) is never mistaken for a timeout.
module wait_timer #(
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= 16'd0;
        end else if (enable) begin
            count <= count + 16'd1;
        end
    end

    assign expired = enable && (count == (TIMEOUT - 16'd1));

endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle sequencer for the NPC core.
// Steps each instruction FETCH -> EXEC -> [MEM] -> WB and owns PC, IR and the
// retired-instruction counter.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   inst_req/inst_addr      : fetch request and address (= pc)
//   inst_valid/inst_rdata   : fetch response; only looked at in FETCH
//   inst, pc                : IR and PC, fed to idu/exu
//   dnpc                    : next PC from exu; taken in WB
//   lsu_req/lsu_we/lsu_done : data-memory request, store flag, completion
//   reg_we                  : GPR write enable, one cycle in WB
//   halted, error           : sticky terminal status (ebreak / illegal or timeout)
//   instret                 : retired-instruction count
//   dbg_state               : current sequencer state, for observation only
// Handshake: a request output is high for as long as the FSM sits in the
// state that owns it; the matching response input is only sampled in that
// state, so a response seen in any other state has no effect.
`include "defines.svh"

module core_ctrl
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [15:0] TIMEOUT  = 16'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_valid,
    input  logic [31:0] inst_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic [31:0] dnpc,
    output logic        lsu_req,
    output logic        lsu_we,
    input  logic        lsu_done,
    output logic        reg_we,
    output logic        halted,
    output logic        error,
    output logic [63:0] instret,
    output ctrl_state_e dbg_state
);

    ctrl_state_e state;
    logic [6:0]  opcode;
    logic        waiting;
    logic        timed_out;
    logic        no_writeback;

    assign opcode = inst[6:0];

    // Only cycles that are still waiting advance the timer; any other cycle
    // (including the one where the response arrives) restarts it.
    assign waiting = ((state == FETCH) && !inst_valid) ||
                     ((state == MEM)   && !lsu_done);

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!waiting),
        .enable  (waiting),
        .expired (timed_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            inst    <= NOP_INST;
            instret <= 64'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (inst_valid) begin
                        inst  <= inst_rdata;
                        state <= EXEC;
                    end else if (timed_out) begin
                        state <= ERR;
                    end
                end
                EXEC: begin
                    // ebreak shares the SYSTEM opcode, so match it first.
                    if (inst == EBREAK_INST) begin
                        instret <= instret + 64'd1;
                        state   <= HALT;
                    end else begin
                        case (opcode)
                            `LOAD_OPCODE,
                            `STORE_OPCODE:  state <= MEM;
                            `LUI_OPCODE,
                            `AUIPC_OPCODE,
                            `JAL_OPCODE,
                            `JALR_OPCODE,
                            `BRANCH_OPCODE,
                            `OP_IMM_OPCODE,
                            `OP_OPCODE,
                            `SYSTEM_OPCODE: state <= WB;
                            default:        state <= ERR;
                        endcase
                    end
                end
                MEM: begin
                    if (lsu_done) begin
                        state <= WB;
                    end else if (timed_out) begin
                        state <= ERR;
                    end
                end
                WB: begin
                    pc      <= dnpc;
                    instret <= instret + 64'd1;
                    state   <= FETCH;
                end
                HALT:    state <= HALT;
                ERR:     state <= ERR;
                default: state <= ERR;
            endcase
        end
    end

    // Stores, branches and CSR/system instructions have no GPR result here.
    assign no_writeback = (opcode == `STORE_OPCODE)  ||
                          (opcode == `BRANCH_OPCODE) ||
                          (opcode == `SYSTEM_OPCODE);

    assign inst_req  = (state == FETCH);
    assign inst_addr = pc;
    assign lsu_req   = (state == MEM);
    assign lsu_we    = (state == MEM) && (opcode == `STORE_OPCODE);
    assign reg_we    = (state == WB) && !no_writeback;
    assign halted    = (state == HALT);
    assign error     = (state == ERR);
    assign dbg_state = state;

endmodule

// File: tb/tb_core_ctrl.sv
module tb_core_ctrl;
    import core_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [15:0] TIMEOUT  = 16'd8;

    logic        clk;
    logic        rst_n;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_valid;
    logic [31:0] inst_rdata;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] dnpc;
    logic        lsu_req;
    logic        lsu_we;
    logic        lsu_done;
    logic        reg_we;
    logic        halted;
    logic        error;
    logic [63:0] instret;
    ctrl_state_e dbg_state;

    core_ctrl #(
        .RESET_PC (RESET_PC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_valid (inst_valid),
        .inst_rdata (inst_rdata),
        .inst       (inst),
        .pc         (pc),
        .dnpc       (dnpc),
        .lsu_req    (lsu_req),
        .lsu_we     (lsu_we),
        .lsu_done   (lsu_done),
        .reg_we     (reg_we),
        .halted     (halted),
        .error      (error),
        .instret    (instret),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_pc;
    logic [63:0] exp_instret;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    // Each entry is {expected reg_we, expected IR} for one instruction that must reach WB.
    logic [32:0] exp_q[$];
    int          we_pulses;
    int          lsu_cycles;

    always @(negedge clk) begin
        if (rst_n && reg_we) we_pulses++;
        if (rst_n && lsu_req) lsu_cycles++;
    end

    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n && dbg_state == WB) begin
            if (exp_q.size() == 0) begin
                check("sb_wb_without_issue", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_wb", {31'b0, reg_we, inst}, {31'b0, e});
            end
        end
    end

    task automatic do_reset(input int cycles);
        rst_n      = 1'b0;
        inst_valid = 1'b0;
        lsu_done   = 1'b0;
        repeat (cycles) step();
        rst_n       = 1'b1;
        exp_pc      = RESET_PC;
        exp_instret = 64'd0;
        exp_q.delete();
        check("rst_state", 64'(dbg_state), 64'(FETCH));
        check("rst_pc", 64'(pc), 64'(RESET_PC));
        check("rst_ir", 64'(inst), 64'h13);
        check("rst_instret", instret, 64'd0);
        check("rst_outs", 64'({inst_req, lsu_req, lsu_we, reg_we, halted, error}), 64'b100000);
    endtask

    // ---------------- driver ----------------
    // Starts in FETCH and leaves the core back in FETCH after WB.
    task automatic run_insn(input logic [31:0] ir, input logic [31:0] next_pc,
                            input int ival_wait, input int mem_wait);
        logic [6:0] op;
        logic       is_mem;
        logic       is_store;
        logic       exp_we;
        int         we0;
        int         lsu0;
        op       = ir[6:0];
        is_store = (op == 7'b0100011);
        is_mem   = is_store || (op == 7'b0000011);
        exp_we   = !(is_store || op == 7'b1100011 || op == 7'b1110011);
        we0      = we_pulses;
        lsu0     = lsu_cycles;
        exp_q.push_back({exp_we, ir});

        check("fetch_req", 64'({dbg_state == FETCH, inst_req}), 64'b11);
        check("fetch_addr", 64'(inst_addr), 64'(exp_pc));
        repeat (ival_wait) begin
            inst_valid = 1'b0;
            lsu_done   = 1'($urandom_range(0, 1));
            step();
        end
        lsu_done = 1'b0;
        check("fetch_still", 64'({dbg_state == FETCH, inst_req, error}), 64'b110);
        inst_valid = 1'b1;
        inst_rdata = ir;
        step();
        inst_valid = 1'b0;
        inst_rdata = $urandom();
        check("exec_state", 64'(dbg_state), 64'(EXEC));
        check("exec_ir", 64'(inst), 64'(ir));
        check("exec_outs", 64'({inst_req, lsu_req, reg_we}), 64'd0);
        step();
        if (is_mem) begin
            check("mem_state", 64'(dbg_state), 64'(MEM));
            check("mem_we", 64'(lsu_we), 64'(is_store));
            repeat (mem_wait) step();
            lsu_done = 1'b1;
            step();
            lsu_done = 1'b0;
        end
        check("wb_state", 64'(dbg_state), 64'(WB));
        dnpc = next_pc;
        step();
        dnpc        = $urandom();
        exp_pc      = next_pc;
        exp_instret = exp_instret + 64'd1;
        check("post_state", 64'(dbg_state), 64'(FETCH));
        check("post_pc", 64'(pc), 64'(exp_pc));
        check("post_instret", instret, exp_instret);
        check("we_count", 64'(we_pulses - we0), 64'(exp_we));
        check("lsu_count", 64'(lsu_cycles - lsu0), is_mem ? 64'(mem_wait + 1) : 64'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] insn_tab [10];
    logic [31:0] beq_pc;
    int          cnt;
    int          we_snap;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        we_pulses  = 0;
        lsu_cycles = 0;
        rst_n      = 1'b0;
        inst_valid = 1'b0;
        inst_rdata = 32'h0;
        lsu_done   = 1'b0;
        dnpc       = 32'h0;
        insn_tab   = '{32'h0010_0093, 32'h0020_81b3, 32'h1234_50b7, 32'h0000_0097,
                       32'h0040_006f, 32'h0000_8067, 32'h0000_2103, 32'h0020_2023,
                       32'h0020_9463, 32'h3000_1073};

        // 1: zero-wait addi
        do_reset(2);
        run_insn(32'h0010_0093, 32'h8000_0004, 0, 0);
        // 2: load with 3 wait cycles
        run_insn(32'h0000_2103, exp_pc + 32'd4, 0, 3);
        // 3: store then beq to itself
        run_insn(32'h0020_2023, exp_pc + 32'd4, 0, 0);
        beq_pc = exp_pc;
        run_insn(32'h0000_0063, beq_pc, 0, 0);
        check("beq_pc_same", 64'(pc), 64'(beq_pc));
        check("instret_after_4", instret, 64'd4);
        // mixed traffic, including a PC that wraps
        run_insn(32'h0000_006f, 32'hFFFF_FFFC, 1, 0);
        run_insn(32'h0000_0093, 32'h0000_0000, 0, 0);
        for (int i = 0; i < 12; i++) begin
            run_insn(insn_tab[$urandom_range(0, 9)], $urandom(),
                     $urandom_range(0, 6), $urandom_range(0, 5));
        end

        // 4: ebreak halts
        inst_valid = 1'b1;
        inst_rdata = EBREAK_INST;
        step();
        inst_valid = 1'b0;
        check("ebreak_exec", 64'(dbg_state), 64'(EXEC));
        step();
        check("halt_flags", 64'({halted, error}), 64'b10);
        check("halt_instret", instret, exp_instret + 64'd1);
        check("halt_pc", 64'(pc), 64'(exp_pc));
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            inst_valid = 1'b1;
            lsu_done   = 1'b1;
            inst_rdata = $urandom();
            step();
            if (inst_req || lsu_req || reg_we || !halted) cnt++;
        end
        inst_valid = 1'b0;
        lsu_done   = 1'b0;
        check("halt_quiet_cycles", 64'(cnt), 64'd0);
        check("halt_frozen", {pc, inst}, {exp_pc, EBREAK_INST});

        // 5a: illegal opcode
        do_reset(1);
        inst_valid = 1'b1;
        inst_rdata = 32'h0000_007F;
        step();
        inst_valid = 1'b0;
        step();
        check("illegal_state", 64'(dbg_state), 64'(ERR));
        check("illegal_flags", 64'({error, halted, inst_req}), 64'b100);
        check("illegal_ir_kept", 64'(inst), 64'h7F);
        check("illegal_instret", instret, 64'd0);

        // 5b: fetch timeout
        do_reset(1);
        repeat (7) step();
        check("fetch_to_c7", 64'({dbg_state == FETCH, error}), 64'b10);
        step();
        check("fetch_to_c8", 64'({dbg_state == ERR, error, inst_req}), 64'b110);
        check("fetch_to_ir", 64'(inst), 64'h13);

        // 5c: response on the last allowed cycle wins
        do_reset(1);
        run_insn(32'h0010_0093, RESET_PC + 32'd4, 7, 0);

        // data-side timeout
        inst_valid = 1'b1;
        inst_rdata = 32'h0000_2103;
        step();
        inst_valid = 1'b0;
        step();
        repeat (7) step();
        check("mem_to_c7", 64'({dbg_state == MEM, lsu_req, error}), 64'b110);
        step();
        check("mem_to_c8", 64'({dbg_state == ERR, lsu_req, error}), 64'b101);

        // 6: reset in the middle of MEM
        do_reset(1);
        run_insn(32'h0010_0093, 32'h8000_0100, 0, 0);
        inst_valid = 1'b1;
        inst_rdata = 32'h0000_2103;
        step();
        inst_valid = 1'b0;
        step();
        check("pre_rst_mem", 64'({dbg_state == MEM, lsu_req}), 64'b11);
        do_reset(1);
        we_snap = we_pulses;
        lsu_done = 1'b1;
        repeat (3) step();
        lsu_done = 1'b0;
        check("late_done_state", 64'({dbg_state == FETCH, lsu_req, error}), 64'b100);
        check("late_done_we", 64'(we_pulses - we_snap), 64'd0);
        check("late_done_instret", instret, 64'd0);
        run_insn(32'h0020_81b3, RESET_PC + 32'd4, 0, 0);

        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
